load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits directly downstream of the single-cycle datapath's memory-address/write-data outputs and upstream of its load-data input.
- Converts the core's byte/half/word load/store intent into a word-aligned request/ready bus transaction with byte enables.
- Extends load data by funct3 and stalls the core until the access completes or times out.

Parameters:
- TIMEOUT, 16, bus wait cycles in REQ before forcing completion with BusErr (must be >=1).
- CNT_W, 5, width of the wait counter (must hold TIMEOUT).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- MemRead  in  1  load requested this instruction.
- MemWrite  in  1  store requested this instruction.
- Funct3  in  3  Instr[14:12]: size and sign.
- Addr  in  32  byte address (ALU result).
- WrData  in  32  store data (rs2).
- ReadData  out  32  extended load data to the result mux.
- Stall  out  1  hold PC and register-file write this cycle.
- MisalignErr  out  1  misaligned access flag (combinational).
- BusErr  out  1  timeout flag, valid in DONE.
- bus_req  out  1  request valid.
- bus_we  out  1  1=write.
- bus_addr  out  32  {Addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-steered store data.
- bus_ready  in  1  slave accepts/completes this cycle.
- bus_rdata  in  32  read word, valid with bus_ready.

Behaviour:
- Reset: state IDLE; bus_req, bus_we, bus_be, BusErr = 0; bus_addr, bus_wdata, captured data = 0. Reset is async: bus_req drops immediately, even mid-REQ; the transaction is abandoned.
- Access = MemRead|MemWrite. If both are set, treat as a write.
- Alignment rules:
  - Funct3[1:0]=01 (half): misaligned if Addr[0]=1.
  - Funct3[1:0]=10/11 (word): misaligned if Addr[1:0]!=0.
  - Byte accesses are never misaligned.
  - On a misaligned access: MisalignErr=1 combinationally, no bus request, Stall=0, ReadData=0, store dropped.
- IDLE: on an aligned access, Stall=1 combinationally. At the next edge, register addr/be/wdata/we, set bus_req=1, go to REQ.
- REQ: Stall=1; bus_req held with stable fields; wait counter increments each cycle.
  - bus_ready=1: capture bus_rdata, clear bus_req at the edge, go to DONE, BusErr=0.
  - Counter reaches TIMEOUT-1 without ready: go to DONE, BusErr=1, captured data=0.
- DONE: Stall=0; ReadData valid; core advances at this edge. Next state IDLE; counter cleared.
- Latency: an aligned access with zero-wait ready stalls 2 cycles, and the instruction retires in the 3rd. A back-to-back access enters REQ one cycle after DONE.
- Stores:
  - sb: be=4'b0001<<Addr[1:0], wdata={4{WrData[7:0]}}.
  - sh: be=4'b0011<<{Addr[1],1'b0}, wdata={2{WrData[15:0]}}.
  - sw: be=4'b1111, wdata=WrData.
- Loads: select the lane by Addr[1:0], then extend.
  - 000 lb: sign-extend byte.
  - 100 lbu: zero-extend byte.
  - 001 lh: sign-extend half.
  - 101 lhu: zero-extend half.
  - 010/011/110/111: word.
- bus_be on reads: the same pattern as stores (informational).
- ReadData=0 whenever state!=DONE or the access is a write.
- If MemRead/MemWrite deassert while in REQ (illegal for a stalled core), the transaction still completes; inputs are sampled only in IDLE.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state encoding IDLE=2'd0, REQ=2'd1, DONE=2'd2.
- One combinational sub-module, lsu_lane: store be/wdata steering plus load lane select and extension, reused by both paths.
- FSM and counter live in load_store_unit.

Test Plan:
- sw Addr=0x100, WrData=0xDEADBEEF, ready after 1 cycle -> bus_addr=0x100, be=1111, wdata=0xDEADBEEF, we=1; Stall high 2 cycles, then low.
- lb Addr=0x103, bus_rdata=0x80FF1234 -> ReadData=0xFFFFFF80. Same with lbu -> 0x00000080.
- lh Addr=0x102, rdata=0x8001AAAA -> 0xFFFF8001. lhu -> 0x00008001. sh Addr=0x102, WrData=0x1234 -> be=1100, wdata=0x12341234.
- lw Addr=0x101 -> MisalignErr=1, bus_req never asserts, Stall=0, ReadData=0.
- lw with bus_ready held 0 -> bus_req high exactly TIMEOUT cycles, then DONE with BusErr=1, ReadData=0, Stall=0.
- reset driven low mid-REQ -> bus_req=0 and Stall=0 asynchronously; after release, state IDLE and a fresh lw completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM state encoding and the alignment rule for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Size is Funct3[1:0]; byte accesses can never be misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            F3_B[1:0]: return 1'b0;
            F3_H[1:0]: return off[0];
            F3_W[1:0]: return |off;
            default:   return |off;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: store byte enables / replicated write data, and load lane select with extension.
// Purely combinational; the store side and the load side are independent.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_data,
    input  logic [2:0]  i_ld_f3,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_ld_word,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_st_be   = 4'b1111;
        o_st_data = i_st_data;
        case (i_st_size)
            F3_B[1:0]: begin
                o_st_be   = 4'b0001 << i_st_off;
                o_st_data = {4{i_st_data[7:0]}};
            end
            F3_H[1:0]: begin
                o_st_be   = 4'b0011 << {i_st_off[1], 1'b0};
                o_st_data = {2{i_st_data[15:0]}};
            end
            default: begin
                o_st_be   = 4'b1111;
                o_st_data = i_st_data;
            end
        endcase
    end

    always_comb begin
        w_byte    = i_ld_word[{i_ld_off, 3'b000} +: 8];
        w_half    = i_ld_off[1] ? i_ld_word[31:16] : i_ld_word[15:0];
        o_ld_data = i_ld_word;
        case (i_ld_f3)
            F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_ld_data = {24'h0, w_byte};
            F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_ld_data = {16'h0, w_half};
            default: o_ld_data = i_ld_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Turns byte/half/word load/store intent into a word-aligned req/ready bus access with byte enables.
// Stalls the core from the issuing cycle until DONE; a bus that never answers is cut off after TIMEOUT cycles.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MisalignErr,
    output logic        BusErr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_req;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [3:0]       r_be;
    logic [31:0]      r_wdata;
    logic [2:0]       r_f3;
    logic [1:0]       r_off;
    logic [31:0]      r_rdata;
    logic             r_buserr;

    logic             w_access;
    logic             w_mis;
    logic             w_go;
    logic [3:0]       w_st_be;
    logic [31:0]      w_st_data;
    logic [31:0]      w_ld_data;

    assign w_access = MemRead | MemWrite;
    assign w_mis    = is_misaligned(Funct3[1:0], Addr[1:0]);
    assign w_go     = (r_state == IDLE) && w_access && !w_mis;

    lsu_lane u_lane (
        .i_st_size (Funct3[1:0]),
        .i_st_off  (Addr[1:0]),
        .i_st_data (WrData),
        .o_st_be   (w_st_be),
        .o_st_data (w_st_data),
        .i_ld_f3   (r_f3),
        .i_ld_off  (r_off),
        .i_ld_word (bus_rdata),
        .o_ld_data (w_ld_data)
    );

    // Stall is gated by reset so an abandoned access releases the core immediately.
    always_comb begin
        Stall       = reset && (w_go || (r_state == REQ));
        MisalignErr = (r_state == IDLE) && w_access && w_mis;
        ReadData    = ((r_state == DONE) && !r_we) ? r_rdata : 32'h0;
    end

    assign BusErr    = r_buserr;
    assign bus_req   = r_req;
    assign bus_we    = r_we;
    assign bus_addr  = r_addr;
    assign bus_be    = r_be;
    assign bus_wdata = r_wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= 32'h0;
            r_be     <= 4'h0;
            r_wdata  <= 32'h0;
            r_f3     <= 3'h0;
            r_off    <= 2'h0;
            r_rdata  <= 32'h0;
            r_buserr <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_go) begin
                        r_addr  <= {Addr[31:2], 2'b00};
                        r_be    <= w_st_be;
                        r_wdata <= w_st_data;
                        r_we    <= MemWrite;
                        r_f3    <= Funct3;
                        r_off   <= Addr[1:0];
                        r_req   <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (bus_ready) begin
                        r_rdata  <= r_we ? 32'h0 : w_ld_data;
                        r_req    <= 1'b0;
                        r_buserr <= 1'b0;
                        r_state  <= DONE;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_rdata  <= 32'h0;
                        r_req    <= 1'b0;
                        r_buserr <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_cnt    <= '0;
                    r_buserr <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized bench for load_store_unit with a byte-arithmetic reference model.
module tb_load_store_unit;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Addr;
    logic [31:0] WrData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        MisalignErr;
    logic        BusErr;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    int n_pass  = 0;
    int n_total = 0;

    load_store_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .Funct3      (Funct3),
        .Addr        (Addr),
        .WrData      (WrData),
        .ReadData    (ReadData),
        .Stall       (Stall),
        .MisalignErr (MisalignErr),
        .BusErr      (BusErr),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_ready   (bus_ready),
        .bus_rdata   (bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h required %h", tag, obs, exp);
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] w);
        int unsigned v;
        int          sz;
        sz = acc_size(f3);
        if (sz == 4) return w;
        v = w >> (8 * (addr % 4));
        if (sz == 1) begin
            v = v % 256;
            if (!f3[2] && v >= 128) v = v + 32'hFFFFFF00;
        end else begin
            v = v % 65536;
            if (!f3[2] && v >= 32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        sz = acc_size(f3);
        return 4'(((1 << sz) - 1) << (addr % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int sz;
        sz = acc_size(f3);
        if (sz == 1) return (wd % 256) * 32'h01010101;
        if (sz == 2) return (wd % 65536) * 32'h00010001;
        return wd;
    endfunction

    // One complete access; wait_c < 0 means the bus never answers.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdw, input int wait_c,
                             output logic [31:0] o_rd, output logic [3:0] o_be,
                             output logic [31:0] o_wd);
        int   sz;
        int   req_cycles;
        int   bad;
        logic mis;
        sz  = acc_size(f3);
        mis = (addr % sz) != 0;
        MemRead  = rd;
        MemWrite = wr;
        Funct3   = f3;
        Addr     = addr;
        WrData   = wd;
        o_rd = 32'h0;
        o_be = 4'h0;
        o_wd = 32'h0;
        #1;
        check("misalign_flag", MisalignErr, mis);
        if (mis) begin
            check("mis_stall", Stall, 0);
            check("mis_rdata", ReadData, 0);
            @(posedge clk); #1;
            check("mis_no_req", bus_req, 0);
            o_rd = ReadData;
        end else begin
            check("issue_stall", Stall, 1);
            @(posedge clk); #1;
            o_be = bus_be;
            o_wd = bus_wdata;
            check("bus_addr", bus_addr, {addr[31:2], 2'b00});
            check("bus_we", bus_we, wr);
            check("bus_be", bus_be, m_be(f3, addr));
            if (wr) check("bus_wdata", bus_wdata, m_wdata(f3, wd));
            req_cycles = 0;
            bad = 0;
            while (bus_req === 1'b1 && req_cycles < 64) begin
                if (Stall !== 1'b1 || bus_addr !== {addr[31:2], 2'b00}) bad++;
                bus_ready = (wait_c >= 0) && (req_cycles == wait_c);
                bus_rdata = bus_ready ? rdw : $urandom;
                @(posedge clk); #1;
                bus_ready = 1'b0;
                req_cycles++;
            end
            check("req_stable_stalled", bad, 0);
            check("req_cycles", req_cycles, (wait_c < 0) ? TIMEOUT : wait_c + 1);
            check("done_stall", Stall, 0);
            check("done_buserr", BusErr, wait_c < 0);
            check("done_rdata", ReadData, (wr || wait_c < 0) ? 32'h0 : m_load(f3, addr, rdw));
            o_rd = ReadData;
        end
        @(posedge clk); #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    logic [31:0] r_rd, r_wd;
    logic [3:0]  r_be;
    logic [2:0]  f3;
    logic [31:0] a;
    int          kind;

    initial begin
        reset     = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Funct3    = 3'b000;
        Addr      = 32'h0;
        WrData    = 32'h0;
        bus_ready = 1'b0;
        bus_rdata = 32'h0;
        #12;
        check("rst_req", bus_req, 0);
        check("rst_we", bus_we, 0);
        check("rst_be", bus_be, 0);
        check("rst_buserr", BusErr, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_wdata", bus_wdata, 0);
        check("rst_rdata", ReadData, 0);
        check("rst_stall", Stall, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        do_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, r_rd, r_be, r_wd);
        check("sw_be", r_be, 4'b1111);
        check("sw_wdata", r_wd, 32'hDEADBEEF);
        do_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, r_rd, r_be, r_wd);
        check("lb_val", r_rd, 32'hFFFFFF80);
        do_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 1, r_rd, r_be, r_wd);
        check("lbu_val", r_rd, 32'h00000080);
        do_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h8001AAAA, 2, r_rd, r_be, r_wd);
        check("lh_val", r_rd, 32'hFFFF8001);
        do_access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h8001AAAA, 0, r_rd, r_be, r_wd);
        check("lhu_val", r_rd, 32'h00008001);
        do_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0, 0, r_rd, r_be, r_wd);
        check("sh_be", r_be, 4'b1100);
        check("sh_wdata", r_wd, 32'h12341234);
        do_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, r_rd, r_be, r_wd);
        do_access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h12345678, -1, r_rd, r_be, r_wd);
        do_access(1'b1, 1'b1, 3'b000, 32'h105, 32'h000000A5, 32'hFFFFFFFF, 0, r_rd, r_be, r_wd);
        check("rw_is_write_be", r_be, 4'b0010);

        // Reset in the middle of a waiting read.
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        Funct3   = 3'b010;
        Addr     = 32'h200;
        @(posedge clk); #1;
        check("pre_rst_req", bus_req, 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("async_rst_req", bus_req, 0);
        check("async_rst_stall", Stall, 0);
        MemRead = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_rst_req", bus_req, 0);
        check("post_rst_rdata", ReadData, 0);
        do_access(1'b1, 1'b0, 3'b010, 32'h204, 32'h0, 32'hCAFEF00D, 1, r_rd, r_be, r_wd);
        check("post_rst_lw", r_rd, 32'hCAFEF00D);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            f3   = 3'($urandom_range(0, 7));
            a    = $urandom;
            if ($urandom_range(0, 4) != 0) a = a & ~(acc_size(f3) - 1);
            do_access(kind != 1, kind != 0, f3, a, $urandom, $urandom,
                      $urandom_range(0, 3), r_rd, r_be, r_wd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
